// File: rtl/sha3_param_pkg.sv
// ============================================================================
//  Module      : sha3_param_pkg
//  Description : Shared SHA-3 rate, domain/padding constants and packer state
//                type for the message packer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha3_param_pkg;

    localparam int         SHA3_256_RATE_LANES = 17;
    localparam int         SHA3_512_RATE_LANES = 9;
    localparam logic [7:0] SHA3_DOMAIN_SHA3    = 8'h06;
    localparam logic [7:0] SHA3_DOMAIN_SHAKE   = 8'h1F;
    localparam logic [7:0] SHA3_PAD_END        = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } sha3_packer_state_e;

    // Byte counts above a full word are treated as a full word.
    function automatic logic [2:0] clamp_nbytes(input logic [2:0] i_n);
        return (i_n > 3'd4) ? 3'd4 : i_n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sha3_pad_lane.sv
// ============================================================================
//  Module      : sha3_pad_lane
//  Description : Combinational lane shaper: keeps the first i_nbytes bytes,
//                inserts the domain byte right after them and ORs the end bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha3_pad_lane
    import sha3_param_pkg::*;
(
    input  logic [63:0] i_lane,
    input  logic [3:0]  i_nbytes,
    input  logic        i_dom_en,
    input  logic [7:0]  i_domain,
    input  logic        i_end_en,
    output logic [63:0] o_lane
);

    for (genvar b = 0; b < 8; b++) begin : g_byte
        logic [7:0] w_byte;

        // The domain byte lands on the first masked-off byte, so OR is safe.
        always_comb begin
            w_byte = (4'(b) < i_nbytes) ? i_lane[8*b +: 8] : 8'h00;
            if (i_dom_en && (4'(b) == i_nbytes)) begin
                w_byte = w_byte | i_domain;
            end
            if (i_end_en && (b == 7)) begin
                w_byte = w_byte | SHA3_PAD_END;
            end
        end

        assign o_lane[8*b +: 8] = w_byte;
    end

endmodule

`default_nettype wire

// File: rtl/sha3_msg_packer.sv
// ============================================================================
//  Module      : sha3_msg_packer
//  Description : Packs 32-bit message words into 64-bit Keccak absorb lanes
//                and appends SHA-3 padding. Macro SHA3_PACKER_SHAKE_EN adds
//                the shake_i port selecting the SHAKE domain byte.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha3_msg_packer
    import sha3_param_pkg::*;
#(
    parameter int RATE_LANES = SHA3_256_RATE_LANES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        in_last_i,
    input  logic [2:0]  in_nbytes_i,
    output logic [63:0] lane_o,
    output logic        lane_valid_o,
    input  logic        lane_ready_i,
    output logic        block_end_o,
    output logic        msg_end_o,
`ifdef SHA3_PACKER_SHAKE_EN
    input  logic        shake_i,
`endif
    output logic        busy_o
);

    localparam int                c_cnt_w    = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(RATE_LANES - 1);

    sha3_packer_state_e r_state;
    sha3_packer_state_e w_state_nxt;

    logic               r_ready_en;
    logic               r_half;
    logic [31:0]        r_lo;
    logic [63:0]        r_lane;
    logic               r_lane_valid;
    logic               r_block_end;
    logic               r_msg_end;
    logic [c_cnt_w-1:0] r_lane_cnt;
    logic               r_dom_pending;
    logic               r_end_loaded;

    logic               w_out_xfer;
    logic               w_out_free;
    logic               w_in_ready;
    logic               w_in_xfer;
    logic               w_load_in;
    logic               w_pad_gen;
    logic               w_load;
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic [c_cnt_w-1:0] w_load_idx;
    logic               w_at_last;
    logic [3:0]         w_in_nbytes;
    logic               w_in_short;
    logic [7:0]         w_domain;
    logic               w_shake;

    logic [63:0]        w_raw_lane;
    logic [3:0]         w_pad_nbytes;
    logic               w_dom_en;
    logic               w_end_en;
    logic [63:0]        w_pad_lane;

`ifdef SHA3_PACKER_SHAKE_EN
    logic               r_shake;
    assign w_shake = (r_state == ST_IDLE) ? shake_i : r_shake;
`else
    assign w_shake = 1'b0;
`endif
    assign w_domain = w_shake ? SHA3_DOMAIN_SHAKE : SHA3_DOMAIN_SHA3;

    assign w_out_xfer = r_lane_valid & lane_ready_i;
    assign w_out_free = ~r_lane_valid | lane_ready_i;
    assign w_in_ready = r_ready_en & w_out_free
                      & ((r_state == ST_IDLE) | (r_state == ST_PACK));
    assign w_in_xfer  = in_valid_i & w_in_ready;
    assign w_load_in  = w_in_xfer & (r_half | in_last_i);
    assign w_pad_gen  = (r_state == ST_PAD) & ~r_end_loaded & w_out_free;
    assign w_load     = w_load_in | w_pad_gen;

    // Index of the lane being loaded: the held lane may leave this same cycle.
    assign w_cnt_inc  = (r_lane_cnt == c_last_idx) ? '0 : r_lane_cnt + 1'b1;
    assign w_load_idx = w_out_xfer ? w_cnt_inc : r_lane_cnt;
    assign w_at_last  = (w_load_idx == c_last_idx);

    assign w_in_nbytes = in_last_i
                       ? ({1'b0, (r_half ? 3'd4 : 3'd0)} + {1'b0, clamp_nbytes(in_nbytes_i)})
                       : 4'd8;
    assign w_in_short  = (w_in_nbytes != 4'd8);

    always_comb begin
        w_raw_lane   = r_half ? {in_data_i, r_lo} : {32'h0, in_data_i};
        w_pad_nbytes = w_in_nbytes;
        w_dom_en     = in_last_i & w_in_short;
        w_end_en     = in_last_i & w_in_short & w_at_last;
        if (w_pad_gen) begin
            w_raw_lane   = 64'h0;
            w_pad_nbytes = 4'd0;
            w_dom_en     = r_dom_pending;
            w_end_en     = w_at_last;
        end
    end

    sha3_pad_lane u_pad (
        .i_lane   (w_raw_lane),
        .i_nbytes (w_pad_nbytes),
        .i_dom_en (w_dom_en),
        .i_domain (w_domain),
        .i_end_en (w_end_en),
        .o_lane   (w_pad_lane)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_in_xfer) w_state_nxt = in_last_i ? ST_PAD : ST_PACK;
            ST_PACK: if (w_in_xfer && in_last_i) w_state_nxt = ST_PAD;
            ST_PAD:  if (w_out_xfer && r_msg_end) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_ready_en    <= 1'b0;
            r_half        <= 1'b0;
            r_lo          <= 32'h0;
            r_lane        <= 64'h0;
            r_lane_valid  <= 1'b0;
            r_block_end   <= 1'b0;
            r_msg_end     <= 1'b0;
            r_lane_cnt    <= '0;
            r_dom_pending <= 1'b0;
            r_end_loaded  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ready_en <= 1'b1;

            if (w_in_xfer) begin
                if (in_last_i) begin
                    r_half <= 1'b0;
                end else begin
                    r_half <= ~r_half;
                    if (!r_half) begin
                        r_lo <= in_data_i;
                    end
                end
            end

            if (w_out_xfer) begin
                r_lane_cnt <= w_cnt_inc;
            end

            if (w_load) begin
                r_lane       <= w_pad_lane;
                r_lane_valid <= 1'b1;
                r_block_end  <= w_at_last;
                r_msg_end    <= w_end_en;
            end else if (w_out_xfer) begin
                r_lane_valid <= 1'b0;
            end

            // A final lane completely full of data pushes the domain byte onward.
            if (w_load_in && in_last_i) begin
                r_dom_pending <= ~w_in_short;
            end else if (w_pad_gen) begin
                r_dom_pending <= 1'b0;
            end

            if (w_load && w_end_en) begin
                r_end_loaded <= 1'b1;
            end else if (r_state == ST_DONE) begin
                r_end_loaded <= 1'b0;
            end
        end
    end

`ifdef SHA3_PACKER_SHAKE_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shake <= 1'b0;
        end else if (w_in_xfer && (r_state == ST_IDLE)) begin
            r_shake <= shake_i;
        end
    end
`endif

    assign in_ready_o   = w_in_ready;
    assign lane_o       = r_lane;
    assign lane_valid_o = r_lane_valid;
    assign block_end_o  = r_block_end;
    assign msg_end_o    = r_msg_end;
    assign busy_o       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sha3_msg_packer.sv
// ============================================================================
//  Module      : tb_sha3_msg_packer
//  Description : Randomized self-checking bench with a byte-level SHA-3 pad model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha3_msg_packer;

    localparam int RL = 17;
    localparam int RB = RL * 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] in_data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        in_last_i;
    logic [2:0]  in_nbytes_i;
    logic [63:0] lane_o;
    logic        lane_valid_o;
    logic        lane_ready_i;
    logic        block_end_o;
    logic        msg_end_o;
    logic        busy_o;
`ifdef SHA3_PACKER_SHAKE_EN
    logic        shake_i = 1'b0;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]  g_msg[$];
    logic [63:0] g_got[$];

    always #5 clk = ~clk;

    sha3_msg_packer #(.RATE_LANES(RL)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_data_i    (in_data_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_last_i    (in_last_i),
        .in_nbytes_i  (in_nbytes_i),
        .lane_o       (lane_o),
        .lane_valid_o (lane_valid_o),
        .lane_ready_i (lane_ready_i),
        .block_end_o  (block_end_o),
        .msg_end_o    (msg_end_o),
`ifdef SHA3_PACKER_SHAKE_EN
        .shake_i      (shake_i),
`endif
        .busy_o       (busy_o)
    );

    // Drives g_msg through the DUT and compares every lane with the padded byte stream.
    task automatic run_msg(input bit extra_word, input bit rand_flow, input bit stall_mode);
        logic [7:0]  p[$];
        logic [63:0] exp_l[$];
        logic [31:0] wd[$];
        logic        wl[$];
        logic [2:0]  wn[$];
        logic [63:0] v;
        logic [63:0] held;
        logic [31:0] w;
        logic [2:0]  nb;
        int len, i, rem, wi, got, cyc, stall_left;
        bit done, stalled, in_fire, out_fire;

        len = g_msg.size();
        p = g_msg;
        p.push_back(8'h06);
        while (p.size() % RB != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        for (int l = 0; l < p.size() / 8; l++) begin
            v = '0;
            for (int b = 0; b < 8; b++) v[8*b +: 8] = p[8*l + b];
            exp_l.push_back(v);
        end

        i = 0; done = 0;
        while (!done) begin
            rem = len - i;
            w = $urandom;
            if (rem > 4 || (rem == 4 && extra_word)) begin
                for (int b = 0; b < 4; b++) w[8*b +: 8] = g_msg[i + b];
                wd.push_back(w); wl.push_back(1'b0); wn.push_back(3'd4);
                i += 4;
            end else begin
                for (int b = 0; b < rem; b++) w[8*b +: 8] = g_msg[i + b];
                nb = 3'(rem);
                if (rem == 4) nb = 3'($urandom_range(4, 7));
                wd.push_back(w); wl.push_back(1'b1); wn.push_back(nb);
                done = 1;
            end
        end

        g_got.delete();
        wi = 0; got = 0; cyc = 0; stall_left = 0; stalled = 0;
        @(posedge clk); #1;
        while (got < exp_l.size() && cyc < 4000) begin
            if (wi < wd.size() && (!rand_flow || $urandom_range(0, 3) != 0)) begin
                in_valid_i = 1'b1; in_data_i = wd[wi]; in_last_i = wl[wi]; in_nbytes_i = wn[wi];
            end else begin
                in_valid_i = 1'b0; in_data_i = $urandom; in_last_i = 1'b0; in_nbytes_i = 3'd0;
            end
            if (stall_left > 0) begin
                lane_ready_i = 1'b0;
            end else if (stall_mode && !stalled && got == 2 && lane_valid_o) begin
                stalled = 1; stall_left = 5; held = lane_o; lane_ready_i = 1'b0;
            end else begin
                lane_ready_i = rand_flow ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            @(negedge clk);
            if (stall_left > 0) begin
                n_total++;
                if (lane_o !== held) $display("FAIL stall_lane_stable: got %h expected %h", lane_o, held);
                else n_pass++;
                n_total++;
                if (in_ready_o !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0", in_ready_o);
                else n_pass++;
                stall_left--;
            end
            in_fire  = in_valid_i && in_ready_o;
            out_fire = lane_valid_o && lane_ready_i;
            if (out_fire) begin
                n_total++;
                if (lane_o !== exp_l[got]) $display("FAIL lane[%0d]: got %h expected %h", got, lane_o, exp_l[got]);
                else n_pass++;
                n_total++;
                if (block_end_o !== ((got % RL) == RL - 1))
                    $display("FAIL block_end[%0d]: got %b expected %b", got, block_end_o, (got % RL) == RL - 1);
                else n_pass++;
                n_total++;
                if (msg_end_o !== (got == exp_l.size() - 1))
                    $display("FAIL msg_end[%0d]: got %b expected %b", got, msg_end_o, got == exp_l.size() - 1);
                else n_pass++;
                g_got.push_back(lane_o);
                got++;
            end
            @(posedge clk); #1;
            if (in_fire) wi++;
            cyc++;
        end

        n_total++;
        if (got != exp_l.size()) $display("FAIL lane_count: got %0d expected %0d (timeout)", got, exp_l.size());
        else n_pass++;
        n_total++;
        if (wi != wd.size()) $display("FAIL words_consumed: got %0d expected %0d", wi, wd.size());
        else n_pass++;

        in_valid_i = 1'b0; in_last_i = 1'b0; lane_ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_total++;
            if (lane_valid_o !== 1'b0) $display("FAIL extra_lane: got lane_valid %b expected 0", lane_valid_o);
            else n_pass++;
        end
        n_total++;
        if (busy_o !== 1'b0 || in_ready_o !== 1'b1)
            $display("FAIL idle_after_msg: got busy %b ready %b expected busy 0 ready 1", busy_o, in_ready_o);
        else n_pass++;
    endtask

    task automatic fill_random(input int len);
        g_msg.delete();
        for (int k = 0; k < len; k++) g_msg.push_back(8'($urandom));
    endtask

    task automatic test_reset;
        reset_n = 1'b0; in_valid_i = 1'b0; in_data_i = '0; in_last_i = 1'b0;
        in_nbytes_i = '0; lane_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({lane_o, lane_valid_o, block_end_o, msg_end_o, busy_o, in_ready_o} !== 69'h0)
            $display("FAIL reset_outputs: got lane %h v%b be%b me%b busy%b rdy%b expected all 0",
                     lane_o, lane_valid_o, block_end_o, msg_end_o, busy_o, in_ready_o);
        else n_pass++;
        reset_n = 1'b1;
        #1;
        n_total++;
        if (in_ready_o !== 1'b0) $display("FAIL ready_at_release: got %b expected 0", in_ready_o);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (in_ready_o !== 1'b1) $display("FAIL ready_after_release: got %b expected 1", in_ready_o);
        else n_pass++;
    endtask

    task automatic test_empty;
        g_msg.delete();
        run_msg(1'b0, 1'b0, 1'b0);
        n_total++;
        if (g_got.size() < 1 || g_got[0] !== 64'h06) $display("FAIL empty_lane0: expected 0000000000000006");
        else n_pass++;
        n_total++;
        if (g_got.size() < 17 || g_got[16] !== 64'h8000000000000000) $display("FAIL empty_lane16: expected 8000000000000000");
        else n_pass++;
    endtask

    task automatic test_abc;
        g_msg.delete();
        g_msg.push_back(8'h61); g_msg.push_back(8'h62); g_msg.push_back(8'h63);
        run_msg(1'b0, 1'b0, 1'b0);
        n_total++;
        if (g_got.size() < 1 || g_got[0] !== 64'h0000000006636261) $display("FAIL abc_lane0: expected 0000000006636261");
        else n_pass++;
        n_total++;
        if (g_got.size() < 17 || g_got[16] !== 64'h8000000000000000) $display("FAIL abc_lane16: expected 8000000000000000");
        else n_pass++;
    endtask

    task automatic test_len135;
        fill_random(135);
        run_msg(1'b0, 1'b1, 1'b0);
        n_total++;
        if (g_got.size() != 17 || g_got[16][63:56] !== 8'h86)
            $display("FAIL len135_byte: got %0d lanes expected 17 with top byte 86", g_got.size());
        else n_pass++;
    endtask

    task automatic test_len136(input bit extra_word);
        fill_random(136);
        run_msg(extra_word, 1'b0, 1'b0);
        n_total++;
        if (g_got.size() != 34 || g_got[17] !== 64'h06 || g_got[33] !== 64'h8000000000000000)
            $display("FAIL len136_block2: got %0d lanes expected 34 with lane17=06 lane33=8000000000000000", g_got.size());
        else n_pass++;
    endtask

    task automatic test_stall;
        fill_random(60);
        run_msg(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        for (int m = 0; m < 12; m++) begin
            fill_random($urandom_range(0, 300));
            run_msg(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset_in_pad;
        @(posedge clk); #1;
        in_valid_i = 1'b1; in_data_i = 32'h00636261; in_last_i = 1'b1; in_nbytes_i = 3'd3;
        lane_ready_i = 1'b0;
        @(posedge clk); #1;
        in_valid_i = 1'b0; in_last_i = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy_o !== 1'b1 || lane_valid_o !== 1'b1)
            $display("FAIL pad_precondition: got busy %b lane_valid %b expected 1 1", busy_o, lane_valid_o);
        else n_pass++;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({lane_o, lane_valid_o, block_end_o, msg_end_o, busy_o, in_ready_o} !== 69'h0)
            $display("FAIL pad_reset_outputs: got lane %h v%b busy%b rdy%b expected all 0",
                     lane_o, lane_valid_o, busy_o, in_ready_o);
        else n_pass++;
        reset_n = 1'b1; lane_ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_total++;
            if (lane_valid_o !== 1'b0) $display("FAIL pad_reset_stale_lane: got %b expected 0", lane_valid_o);
            else n_pass++;
        end
        test_empty();
    endtask

    initial begin
        test_reset();
        test_empty();
        test_abc();
        test_len135();
        test_len136(1'b0);
        test_len136(1'b1);
        test_stall();
        test_random();
        test_reset_in_pad();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
